// File: rtl/z80_bus_responder.sv
// Memory and I/O slave for the tv80s bus: wait-state insertion, interrupt vector,
// one write commit per bus cycle, write statistics and a backdoor memory port.
module z80_bus_responder #(
  parameter int         MEM_AW   = 16,
  parameter int         IO_AW    = 8,
  parameter int         MEM_WAIT = 0,
  parameter int         IO_WAIT  = 1,
  parameter logic [7:0] INTA_VEC = 8'hFF,
  parameter int         CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              m1_n,
  input  logic              rfsh_n,
  input  logic [15:0]       addr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_di,
  output logic              wait_n,
  input  logic              bd_we,
  input  logic [MEM_AW-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic [7:0]        bd_rdata,
  output logic [CNT_W-1:0]  mem_wr_cnt,
  output logic [CNT_W-1:0]  io_wr_cnt,
  output logic [15:0]       last_wr_addr,
  output logic [7:0]        last_wr_data,
  output logic              last_wr_io,
  output logic              bd_collide,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_HOLD} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       cyc_io;

  logic [7:0] mem [0:(1<<MEM_AW)-1];
  logic [7:0] io  [0:(1<<IO_AW)-1];

  logic              strobe, is_mem, is_io, is_inta;
  logic              commit, mem_commit, io_commit;
  logic [3:0]        load;
  logic [MEM_AW-1:0] mem_idx;
  logic [IO_AW-1:0]  io_idx;

  assign strobe     = !rd_n || !wr_n;
  assign is_mem     = !mreq_n && rfsh_n && strobe;
  assign is_io      = !iorq_n && m1_n && strobe;
  assign is_inta    = !iorq_n && !m1_n;
  assign mem_idx    = addr[MEM_AW-1:0];
  assign io_idx     = addr[IO_AW-1:0];
  assign load       = is_mem ? 4'(MEM_WAIT) : 4'(IO_WAIT);
  // Only the single ACTIVE edge of a cycle may write; HOLD absorbs long strobes.
  assign commit     = (state == S_ACTIVE) && !wr_n;
  assign mem_commit = commit && !cyc_io;
  assign io_commit  = commit && cyc_io;
  assign bd_rdata   = mem[bd_addr];
  assign dbg_state  = state;

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cyc_io       <= 1'b0;
      wait_n       <= 1'b1;
      cpu_di       <= 8'h00;
      mem_wr_cnt   <= '0;
      io_wr_cnt    <= '0;
      last_wr_addr <= '0;
      last_wr_data <= '0;
      last_wr_io   <= 1'b0;
      bd_collide   <= 1'b0;
    end else begin
      if (is_inta) cpu_di <= INTA_VEC;
      if (commit) begin
        last_wr_addr <= addr;
        last_wr_data <= cpu_dout;
        last_wr_io   <= cyc_io;
        if (cyc_io) begin
          if (io_wr_cnt != '1) io_wr_cnt <= io_wr_cnt + CNT_W'(1);
        end else begin
          if (mem_wr_cnt != '1) mem_wr_cnt <= mem_wr_cnt + CNT_W'(1);
        end
      end
      if (mem_commit && bd_we && (bd_addr == mem_idx)) bd_collide <= 1'b1;
      case (state)
        S_IDLE: begin
          if (is_mem || is_io) begin
            cyc_io <= !is_mem;
            if (load != 4'd0) begin
              cnt    <= load;
              wait_n <= 1'b0;
              state  <= S_WAIT;
            end else begin
              state <= S_ACTIVE;
            end
          end
        end
        S_WAIT: begin
          // Strobes released while still waiting: abandon the cycle.
          if (!strobe) begin
            wait_n <= 1'b1;
            state  <= S_IDLE;
          end else if (cnt == 4'd1) begin
            cnt    <= 4'd0;
            wait_n <= 1'b1;
            state  <= S_ACTIVE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACTIVE: begin
          if (!rd_n) cpu_di <= cyc_io ? io[io_idx] : mem[mem_idx];
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (mreq_n && iorq_n) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Arrays are not reset; the backdoor write is issued last so it wins a collision.
  always_ff @(negedge clk) begin
    if (mem_commit) mem[mem_idx] <= cpu_dout;
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (io_commit) io[io_idx] <= cpu_dout;
  end

endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Synthesisable memory and I/O slave for the tv80s bus, replacing the ad-hoc behavioural memory/IO models in per-opcode benches.
- Parametrised memory/I/O depth and programmable wait-state insertion (drives wait_n), separate for memory and I/O cycles.
- Interrupt-acknowledge vector response, exactly-once write commit per bus cycle, write logging/counters, and a backdoor port for bench preload and inspection.
- Sits between tv80s and the bench; one instance per CPU.

Parameters:
MEM_AW, 16, memory address bits used; depth 2**MEM_AW, addr[MEM_AW-1:0] indexes (aliasing above).
IO_AW, 8, I/O address bits used; depth 2**IO_AW.
MEM_WAIT, 0, wait states inserted per memory read/write cycle (0..15).
IO_WAIT, 1, extra wait states per I/O cycle (0..15), on top of the Z80 automatic one.
INTA_VEC, 8'hFF, byte returned on interrupt acknowledge (m1_n=0, iorq_n=0).
CNT_W, 16, width of write counters.

Ports:
clk  in  1  CPU clock; all state changes on falling edge, matching tv80s sampling
reset_n  in  1  asynchronous active-low reset
mreq_n  in  1  CPU memory request
iorq_n  in  1  CPU I/O request
rd_n  in  1  CPU read strobe
wr_n  in  1  CPU write strobe
m1_n  in  1  CPU M1
rfsh_n  in  1  CPU refresh
addr  in  16  CPU address bus
cpu_dout  in  8  CPU write data
cpu_di  out  8  read data to CPU
wait_n  out  1  wait request to CPU
bd_we  in  1  backdoor memory write enable
bd_addr  in  MEM_AW  backdoor address
bd_wdata  in  8  backdoor write data
bd_rdata  out  8  backdoor read data, combinational mem[bd_addr]
mem_wr_cnt  out  CNT_W  committed CPU memory writes
io_wr_cnt  out  CNT_W  committed CPU I/O writes
last_wr_addr  out  16  address of last committed write
last_wr_data  out  8  data of last committed write
last_wr_io  out  1  1 if last committed write was I/O
bd_collide  out  1  sticky: backdoor and CPU write same address same edge

Behaviour:
- Reset (reset_n=0, async): wait_n=1, cpu_di=8'h00, counters=0, last_wr_*=0, bd_collide=0, FSM=IDLE. Memory/I/O arrays not cleared.
- Cycle classification at each falling edge:
  - MEM: mreq_n=0, rfsh_n=1, (rd_n=0 or wr_n=0).
  - IO: iorq_n=0, m1_n=1, (rd_n=0 or wr_n=0).
  - INTA: iorq_n=0, m1_n=0.
  - Refresh cycles (rfsh_n=0) are ignored entirely: no wait, no read update, no write.
- FSM states IDLE, WAIT, ACTIVE, HOLD:
  - IDLE: on MEM or IO detect, load cnt=MEM_WAIT or IO_WAIT.
    - cnt>0: wait_n=0, go WAIT.
    - cnt=0: go ACTIVE in the same edge.
  - WAIT: decrement cnt each falling edge; when cnt reaches 0, wait_n=1, go ACTIVE.
  - ACTIVE: one falling edge.
    - Read: latch cpu_di.
    - Write: commit the write.
    - Go HOLD.
  - HOLD: no further commits; return to IDLE when mreq_n=1 and iorq_n=1. Guarantees exactly one commit per bus cycle regardless of strobe length.
  - Strobes deasserting mid-WAIT (abort): wait_n=1, go IDLE, nothing committed.
- Read data:
  - MEM reads: cpu_di = mem[addr[MEM_AW-1:0]], registered.
  - IO reads: cpu_di = io[addr[IO_AW-1:0]], registered.
  - INTA: cpu_di = INTA_VEC on every falling edge while asserted; no wait states; never a write.
  - cpu_di holds its last value otherwise.
- Write commit:
  - Updates the array, last_wr_addr=addr, last_wr_data=cpu_dout, last_wr_io.
  - Increments mem_wr_cnt or io_wr_cnt; counters saturate at all-ones.
- Backdoor:
  - bd_we writes mem[bd_addr] on the falling edge, independent of the FSM.
  - Same address and same edge as a CPU commit: backdoor data wins, bd_collide set (sticky until reset), CPU commit still counted.
- Reset asserted mid-cycle: FSM to IDLE immediately, wait_n=1; a partially waited write is never committed.

Test Plan:
- MEM_WAIT=0: preload mem[0000]=1A, mem[8000]=13 via backdoor; reset CPU with DE=8000 -> after LD A,(DE), A=13, wait_n never low, mem_wr_cnt=0.
- MEM_WAIT=2: CPU writes 5A to 1234 (LD (HL),A) -> wait_n low for exactly 2 falling edges, mem[1234]=5A, mem_wr_cnt=1, last_wr_addr=1234, last_wr_io=0.
- IO_WAIT=1: OUT (34h),A with A=C3, then IN A,(34h) -> io[34]=C3, io_wr_cnt=1, A=C3 after IN, one wait_n pulse per I/O cycle.
- Write strobe held for 5 clocks with MEM_WAIT=0 -> exactly one commit, mem_wr_cnt=1.
- bd_we with bd_addr=1234 on the same edge as the CPU commit to 1234 -> mem[1234]=bd_wdata, bd_collide=1; INTA cycle (m1_n=0, iorq_n=0) -> cpu_di=FF, io_wr_cnt unchanged.
- reset_n pulsed low during WAIT of a write -> wait_n=1 immediately, target byte unchanged, counters=0.
